// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: 4-deep input FIFO feeding an MSB-first shifter
// paced by a free-running prescaler tick.
module bit_serializer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ser_out,
  output logic       ser_tick,
  output logic       busy,
  output logic [2:0] fifo_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bits_left_q, bits_left_d;
  logic       ser_out_q, ser_out_d;
  logic       ser_tick_q, ser_tick_d;

  logic       tick;
  logic       push;
  logic       pop;
  logic       load_slot;
  logic [7:0] head;

  // Full/empty decisions use only the registered count, so neither a pop nor
  // a push can bypass the FIFO within one cycle.
  assign din_ready = (cnt_q < 3'd4);
  assign tick      = (div_cnt_q == DIV_LAST);
  assign push      = din_valid && din_ready;
  assign load_slot = tick && ((state_q == IDLE) || (bits_left_q == 3'd0));
  assign pop       = load_slot && (cnt_q != 3'd0);
  assign head      = mem_q[rd_ptr_q];

  assign ser_out  = ser_out_q;
  assign ser_tick = ser_tick_q;
  assign busy     = (state_q == SHIFT);
  assign fifo_cnt = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
  end

  always_comb begin
    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    ser_out_d   = ser_out_q;
    ser_tick_d  = tick;
    if (load_slot) begin
      if (cnt_q != 3'd0) begin
        ser_out_d   = head[7];
        shreg_d     = {head[6:0], 1'b0};
        bits_left_d = 3'd7;
        state_d     = SHIFT;
      end else begin
        ser_out_d = 1'b0;
        state_d   = IDLE;
      end
    end else if (tick) begin
      ser_out_d   = shreg_q[7];
      shreg_d     = {shreg_q[6:0], 1'b0};
      bits_left_d = bits_left_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q       <= '{default: 8'h00};
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      cnt_q       <= 3'd0;
      div_cnt_q   <= 8'd0;
      state_q     <= IDLE;
      shreg_q     <= 8'h00;
      bits_left_q <= 3'd0;
      ser_out_q   <= 1'b0;
      ser_tick_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      ser_out_q   <= ser_out_d;
      ser_tick_q  <= ser_tick_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer at DIV=4, 16 and 1; a per-instance queue
// holds the expected {busy, ser_out} pair for every upcoming ser_tick.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_a = 8'h00, din_b = 8'h00, din_c = 8'h00;
  logic       dv_a = 1'b0, dv_b = 1'b0, dv_c = 1'b0;
  logic       rdy_a, rdy_b, rdy_c;
  logic       so_a, so_b, so_c;
  logic       st_a, st_b, st_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  logic [1:0] exp_c[$];
  logic [1:0] e_a, e_b, e_c;
  logic [6:0] det_a = 7'h00;
  logic       seen_a = 1'b0;
  logic [7:0] words_b [5];
  int         p;

  bit_serializer #(.DIV(4)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .ser_out(so_a), .ser_tick(st_a), .busy(busy_a), .fifo_cnt(cnt_a));
  bit_serializer #(.DIV(16)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .ser_out(so_b), .ser_tick(st_b), .busy(busy_b), .fifo_cnt(cnt_b));
  bit_serializer #(.DIV(1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
    .ser_out(so_c), .ser_tick(st_c), .busy(busy_c), .fifo_cnt(cnt_c));

  always #5 clk = ~clk;

  // Rising edges seen since reset release; sets the expected prescaler phase.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("tick_a", st_a, (cyc >= 1) && (cyc % 4 == 0));
      check("tick_b", st_b, (cyc >= 1) && (cyc % 16 == 0));
      check("tick_c", st_c, (cyc >= 1));
      if (st_a) begin
        e_a = (exp_a.size() != 0) ? exp_a.pop_front() : 2'b00;
        check("bit_a", {busy_a, so_a}, e_a);
        det_a = {det_a[5:0], so_a};
        if (det_a == 7'b1110010) seen_a = 1'b1;
      end
      if (st_b) begin
        e_b = (exp_b.size() != 0) ? exp_b.pop_front() : 2'b00;
        check("bit_b", {busy_b, so_b}, e_b);
      end
      if (st_c) begin
        e_c = (exp_c.size() != 0) ? exp_c.pop_front() : 2'b00;
        check("bit_c", {busy_c, so_c}, e_c);
      end
    end
  end

  // Stimulus moves 1 time unit after the monitor's sampling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_word(input int inst, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      case (inst)
        0:       exp_a.push_back({1'b1, w[i]});
        1:       exp_b.push_back({1'b1, w[i]});
        default: exp_c.push_back({1'b1, w[i]});
      endcase
    end
  endtask

  task automatic push_word(input int inst, input logic [7:0] w);
    case (inst)
      0:       begin din_a = w; dv_a = 1'b1; end
      1:       begin din_b = w; dv_b = 1'b1; end
      default: begin din_c = w; dv_c = 1'b1; end
    endcase
    step();
    dv_a = 1'b0;
    dv_b = 1'b0;
    dv_c = 1'b0;
  endtask

  task automatic drain(input int inst, input int budget, input int settle, input string tag);
    int n;
    int sz;
    n  = 0;
    sz = (inst == 0) ? exp_a.size() : (inst == 1) ? exp_b.size() : exp_c.size();
    while (sz != 0 && n < budget) begin
      step();
      n++;
      sz = (inst == 0) ? exp_a.size() : (inst == 1) ? exp_b.size() : exp_c.size();
    end
    check(tag, sz, 0);
    repeat (settle) step();
  endtask

  initial begin
    words_b = '{8'h3C, 8'hC3, 8'h5A, 8'h0F, 8'hFF};
    repeat (3) step();
    check("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
    check("rst_ready", {rdy_a, rdy_b, rdy_c}, 3'b111);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_ser", {so_a, st_a, so_c, st_c}, 4'b0000);
    rst = 1'b1;

    // DIV=1: the push cycle is itself a tick, so an idle zero precedes the word.
    exp_c.push_back(2'b00);
    exp_word(2, 8'hA5);
    push_word(2, 8'hA5);
    check("c_cnt_after_push", cnt_c, 1);
    drain(2, 40, 3, "c_drain");

    // DIV=4: single word.
    while (cyc % 4 != 0) step();
    exp_word(0, 8'hE4);
    push_word(0, 8'hE4);
    check("a_cnt_one", cnt_a, 1);
    drain(0, 80, 6, "a_single_drain");
    check("a_idle_busy", busy_a, 0);

    // DIV=4: two words back to back, no gap bit.
    seen_a = 1'b0;
    while (cyc % 4 != 0) step();
    exp_word(0, 8'hE4);
    push_word(0, 8'hE4);
    exp_word(0, 8'h80);
    push_word(0, 8'h80);
    check("a_cnt_two", cnt_a, 2);
    drain(0, 120, 6, "a_pair_drain");
    check("a_detector", seen_a, 1);

    // Push on the tick cycle while empty: that tick emits an idle zero.
    while (cyc % 4 != 3) step();
    exp_a.push_back(2'b00);
    exp_word(0, 8'h81);
    push_word(0, 8'h81);
    check("a_nobypass_cnt", cnt_a, 1);
    check("a_nobypass_busy", busy_a, 0);
    drain(0, 80, 6, "a_nobypass_drain");

    // DIV=16: overfill; the fifth word is dropped.
    while (cyc % 16 != 0) step();
    p = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_word(1, words_b[i]);
      push_word(1, words_b[i]);
      check("b_fill_cnt", cnt_b, (i < 4) ? i + 1 : 4);
    end
    check("b_full_ready", rdy_b, 0);
    while (cyc < p + 16) step();
    check("b_after_pop_cnt", cnt_b, 3);
    check("b_after_pop_ready", rdy_b, 1);
    drain(1, 700, 18, "b_drain");

    // Reset mid-word with three words queued behind the one shifting.
    while (cyc % 4 != 0) step();
    exp_word(0, 8'hF1);
    push_word(0, 8'hF1);
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    push_word(0, 8'h44);
    check("a_push_pop_cnt", cnt_a, 3);
    repeat (9) step();
    check("a_pre_rst_state", {busy_a, so_a}, 2'b11);
    rst = 1'b0;
    #1;
    check("a_rst_ser", so_a, 0);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_cnt", cnt_a, 0);
    check("a_rst_ready", rdy_a, 1);
    check("a_rst_tick", st_a, 0);
    exp_a.delete();
    exp_b.delete();
    exp_c.delete();
    repeat (2) step();
    rst = 1'b1;
    repeat (40) step();
    check("a_post_rst_cnt", cnt_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
